// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x oversampled UART receiver front end.
// Synchronises the raw RX pin, recovers 8-bit frames (optional parity, one stop bit) with a
// 2-of-3 majority vote per bit, and buffers bytes in a show-ahead FIFO.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   io_rxd               raw asynchronous RX pin (idles high)
//   io_enable            receiver enable; low abandons the current frame
//   io_divisor           one oversample tick per (io_divisor+1) clocks
//   io_parityEnable/Odd  parity bit present / odd parity select
//   io_data, io_valid    FIFO head byte and non-empty flag
//   io_ready             consumer accepts the head byte
//   io_parityError, io_framingError, io_overrun  one-clock pulses
//   io_breakDetect       level, set by an all-zero frame with a low stop bit
//   io_busy              receiver FSM is not idle
module uart_rx_frontend #(
  parameter int unsigned DIVISOR_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     io_rxd,
  input  logic                     io_enable,
  input  logic [DIVISOR_WIDTH-1:0] io_divisor,
  input  logic                     io_parityEnable,
  input  logic                     io_parityOdd,
  output logic [7:0]               io_data,
  output logic                     io_valid,
  input  logic                     io_ready,
  output logic                     io_parityError,
  output logic                     io_framingError,
  output logic                     io_overrun,
  output logic                     io_breakDetect,
  output logic                     io_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [DIVISOR_WIDTH-1:0] DivOne = 1;
  localparam logic [AW:0] PtrOne = 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e state;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  logic rx_meta, rxs, rxs_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= io_rxd;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // Oversample tick: held at reload while idle so the first tick is phase-aligned to the start edge.
  logic [DIVISOR_WIDTH-1:0] tick_cnt;
  logic                     tick;

  assign tick = (state != StIdle) && (tick_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (state == StIdle || tick) begin
      tick_cnt <= io_divisor;
    end else begin
      tick_cnt <= tick_cnt - DivOne;
    end
  end

  // Bit timing and majority vote; the third sample is the live rxs at index 9.
  logic [3:0] bit_idx;
  logic       samp7, samp8;
  logic       vote, at_vote, bit_end;

  assign vote    = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);
  assign at_vote = tick && (bit_idx == 4'd9);
  assign bit_end = tick && (bit_idx == 4'd15);

  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_mismatch;
  logic       push_req;

  assign push_req = io_enable && (state == StStop) && at_vote && vote;
  assign io_busy  = (state != StIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= StIdle;
      bit_idx         <= '0;
      samp7           <= 1'b1;
      samp8           <= 1'b1;
      bit_cnt         <= '0;
      shift           <= '0;
      par_mismatch    <= 1'b0;
      io_parityError  <= 1'b0;
      io_framingError <= 1'b0;
      io_breakDetect  <= 1'b0;
    end else begin
      io_parityError  <= 1'b0;
      io_framingError <= 1'b0;
      if (tick) begin
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd7) samp7 <= rxs;
        if (bit_idx == 4'd8) samp8 <= rxs;
      end
      if (!io_enable) begin
        state          <= StIdle;
        io_breakDetect <= 1'b0;
      end else begin
        unique case (state)
          StIdle: begin
            if (!rxs && rxs_prev) begin
              state   <= StStart;
              bit_idx <= '0;
            end
          end
          StStart: begin
            if (at_vote && vote) begin
              state <= StIdle;
            end else if (bit_end) begin
              state        <= StData;
              bit_cnt      <= '0;
              par_mismatch <= 1'b0;
            end
          end
          StData: begin
            if (at_vote) shift <= {vote, shift[7:1]};
            if (bit_end) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= io_parityEnable ? StParity : StStop;
            end
          end
          StParity: begin
            if (at_vote) par_mismatch <= vote != (^shift ^ io_parityOdd);
            if (bit_end) state <= StStop;
          end
          StStop: begin
            // Acted on at the vote so a start edge late in the stop bit is not missed.
            if (at_vote) begin
              if (vote) begin
                io_parityError <= par_mismatch;
                state          <= StIdle;
              end else begin
                io_framingError <= 1'b1;
                if (shift == 8'h00) begin
                  io_breakDetect <= 1'b1;
                  state          <= StBreak;
                end else begin
                  state <= StIdle;
                end
              end
            end
          end
          StBreak: begin
            if (rxs) begin
              io_breakDetect <= 1'b0;
              state          <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  // Show-ahead FIFO with one extra pointer bit to tell full from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && io_ready;
  assign do_push = push_req && (!full || pop);
  assign io_valid = !empty;
  assign io_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      io_overrun <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      io_overrun <= push_req && full && !pop;
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + PtrOne;
      end
      if (pop) rd_ptr <= rd_ptr + PtrOne;
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: drives serial frames on io_rxd and checks delivered bytes and flags
// against a frame-level model (expected-byte queue, flag counters, FIFO occupancy).
module tb_uart_rx_frontend;

  localparam int unsigned FifoDepth = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        io_rxd = 1'b1;
  logic        io_enable = 1'b1;
  logic [11:0] io_divisor = 12'd0;
  logic        io_parityEnable = 1'b0;
  logic        io_parityOdd = 1'b0;
  logic [7:0]  io_data;
  logic        io_valid;
  logic        io_ready = 1'b1;
  logic        io_parityError, io_framingError, io_overrun, io_breakDetect, io_busy;

  uart_rx_frontend #(.DIVISOR_WIDTH(12), .FIFO_DEPTH(FifoDepth)) dut (
    .clk(clk), .resetn(resetn), .io_rxd(io_rxd), .io_enable(io_enable),
    .io_divisor(io_divisor), .io_parityEnable(io_parityEnable), .io_parityOdd(io_parityOdd),
    .io_data(io_data), .io_valid(io_valid), .io_ready(io_ready),
    .io_parityError(io_parityError), .io_framingError(io_framingError),
    .io_overrun(io_overrun), .io_breakDetect(io_breakDetect), .io_busy(io_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int obs_par = 0, obs_frm = 0, obs_ovr = 0;
  int exp_par = 0, exp_frm = 0, exp_ovr = 0;
  bit exp_brk = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Single compare process: every consumed beat must match the model's next byte.
  always @(negedge clk) begin
    if (resetn) begin
      if (io_parityError) obs_par++;
      if (io_framingError) obs_frm++;
      if (io_overrun) obs_ovr++;
      if (io_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (io_valid && io_ready) begin
        got_q.push_back(io_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL beat_data: got %0h, required no byte", io_data);
        end else begin
          check("beat_data", {24'd0, io_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    io_rxd = b;
    wait_clk(n);
  endtask

  // Frame-level model: what the receiver must report for one frame.
  task automatic expect_frame(input logic [7:0] d, input bit pen, input bit podd, input bit pbit,
                              input bit stop);
    bit want_par;
    want_par = (^d) ^ podd;
    if (!stop) begin
      exp_frm++;
      if (d == 8'h00) exp_brk = 1'b1;
    end else begin
      if (exp_q.size() >= FifoDepth) exp_ovr++;
      else exp_q.push_back(d);
      if (pen && (pbit != want_par)) exp_par++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit, input bit stop,
                            input int bc);
    drive(1'b0, bc);
    for (int i = 0; i < 8; i++) drive(d[i], bc);
    if (pen) drive(pbit, bc);
    drive(stop, bc);
    io_rxd = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_parity_pulses"}, obs_par, exp_par);
    check({tag, "_framing_pulses"}, obs_frm, exp_frm);
    check({tag, "_overrun_pulses"}, obs_ovr, exp_ovr);
    check({tag, "_break_level"}, {31'd0, io_breakDetect}, {31'd0, exp_brk});
    check({tag, "_pending_bytes"}, exp_q.size(), 0);
  endtask

  logic [7:0] lit [4];

  initial begin
    // Reset state
    wait_clk(3);
    check("rst_valid", {31'd0, io_valid}, 0);
    check("rst_data", {24'd0, io_data}, 0);
    check("rst_busy", {31'd0, io_busy}, 0);
    check("rst_break", {31'd0, io_breakDetect}, 0);
    check("rst_pulses", {29'd0, io_parityError, io_framingError, io_overrun}, 0);
    resetn = 1'b1;
    wait_clk(5);

    // 8N1 back-to-back at divisor 0, with first-beat latency
    got_q.delete();
    first_valid_cyc = -1;
    expect_frame(8'h55, 0, 0, 0, 1);
    expect_frame(8'hA3, 0, 0, 0, 1);
    begin
      int start_cyc;
      start_cyc = cyc + 1;  // first edge that samples the falling pin
      send_frame(8'h55, 0, 0, 1, 16);
      send_frame(8'hA3, 0, 0, 1, 16);
      wait_clk(40);
      n_checks++;
      if (first_valid_cyc - start_cyc < 155 || first_valid_cyc - start_cyc > 157) begin
        n_err++;
        $display("FAIL first_beat_latency: got %0d, required 155..157", first_valid_cyc - start_cyc);
      end
    end
    check("b2b_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_first", {24'd0, got_q[0]}, 32'h55);
      check("b2b_second", {24'd0, got_q[1]}, 32'hA3);
    end
    check_flags("b2b");

    // Glitch: 4 clocks low
    drive(1'b0, 4);
    io_rxd = 1'b1;
    check("glitch_busy_seen", {31'd0, io_busy}, 1);
    begin
      int n;
      n = 0;
      while (io_busy && n < 10) begin
        wait_clk(1);
        n++;
      end
      check("glitch_busy_clear", {31'd0, io_busy}, 0);
    end
    wait_clk(30);
    check_flags("glitch");

    // Framing error then a good byte
    expect_frame(8'hA5, 0, 0, 0, 0);
    send_frame(8'hA5, 0, 0, 0, 16);
    wait_clk(32);
    expect_frame(8'h3C, 0, 0, 0, 1);
    send_frame(8'h3C, 0, 0, 1, 16);
    wait_clk(40);
    check_flags("framing");

    // Break: 20 bit times low
    expect_frame(8'h00, 0, 0, 0, 0);
    drive(1'b0, 20 * 16);
    check_flags("break_held");
    io_rxd = 1'b1;
    wait_clk(1);
    check("break_hold_1clk", {31'd0, io_breakDetect}, 1);
    wait_clk(2);
    check("break_clear_3clk", {31'd0, io_breakDetect}, 0);
    exp_brk = 1'b0;
    wait_clk(20);
    check_flags("break_done");

    // Parity: odd with a wrong bit, even with a correct bit
    io_parityEnable = 1'b1;
    io_parityOdd = 1'b1;
    expect_frame(8'h01, 1, 1, 1, 1);
    send_frame(8'h01, 1, 1, 1, 16);
    wait_clk(40);
    check_flags("parity_odd");
    io_parityOdd = 1'b0;
    expect_frame(8'h03, 1, 0, 0, 1);
    send_frame(8'h03, 1, 0, 1, 16);
    wait_clk(40);
    check_flags("parity_even");

    // Divisor 3 with even parity
    io_divisor = 12'd3;
    expect_frame(8'h96, 1, 0, 0, 1);
    send_frame(8'h96, 1, 0, 1, 64);
    wait_clk(150);
    check_flags("div3");
    io_divisor = 12'd0;
    io_parityEnable = 1'b0;

    // Overrun
    io_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      expect_frame(8'h11 + 8'(i), 0, 0, 0, 1);
      send_frame(8'h11 + 8'(i), 0, 0, 1, 16);
    end
    wait_clk(40);
    check("ovr_pulses", obs_ovr, exp_ovr);
    check("ovr_valid", {31'd0, io_valid}, 1);
    check("ovr_head", {24'd0, io_data}, 32'h11);
    io_ready = 1'b1;
    wait_clk(10);
    lit[0] = 8'h11; lit[1] = 8'h12; lit[2] = 8'h13; lit[3] = 8'h14;
    check("ovr_drain_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++) check("ovr_drain_byte", {24'd0, got_q[i]}, {24'd0, lit[i]});
    check("ovr_valid_drop", {31'd0, io_valid}, 0);
    check_flags("overrun");

    // Enable drop mid-frame
    drive(1'b0, 16);
    drive(1'b1, 24);
    check("en_busy_before", {31'd0, io_busy}, 1);
    io_enable = 1'b0;
    wait_clk(1);
    check("en_busy_after", {31'd0, io_busy}, 0);
    wait_clk(200);
    io_enable = 1'b1;
    wait_clk(10);
    check_flags("enable");

    // Reset mid-frame with a byte already buffered
    io_ready = 1'b0;
    expect_frame(8'h42, 0, 0, 0, 1);
    send_frame(8'h42, 0, 0, 1, 16);
    wait_clk(20);
    check("pre_rst_valid", {31'd0, io_valid}, 1);
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    io_rxd = 1'b1;  // bit 3 of 0x7E
    wait_clk(8);
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, io_valid}, 0);
    check("mid_rst_data", {24'd0, io_data}, 0);
    check("mid_rst_busy", {31'd0, io_busy}, 0);
    check("mid_rst_pulses", {28'd0, io_parityError, io_framingError, io_overrun, io_breakDetect}, 0);
    exp_q.delete();
    wait_clk(3);
    resetn = 1'b1;
    io_ready = 1'b1;
    wait_clk(20);
    got_q.delete();
    expect_frame(8'h7E, 0, 0, 0, 1);
    send_frame(8'h7E, 0, 0, 1, 16);
    wait_clk(40);
    check("post_rst_count", got_q.size(), 1);
    if (got_q.size() == 1) check("post_rst_byte", {24'd0, got_q[0]}, 32'h7E);
    check_flags("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Oversampling UART receiver front end that feeds the `Uart` core's command path. It takes the raw asynchronous RXD pin (one of the `io_in[7:1]` lines), synchronises it, recovers 8-bit frames with a 16x oversampled majority vote, and checks parity and stop bits. Received bytes are buffered in a small show-ahead FIFO with a valid/ready handshake toward the consumer.

## Interface

- `DIVISOR_WIDTH`, default 12: width of the baud divisor input.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of 2 and at least 2.

- `clk` in 1: single clock; all state is in this domain.
- `resetn` in 1: reset, asynchronous and active-low.
- `io_rxd` in 1: raw asynchronous RX pin; idles high.
- `io_enable` in 1: receiver enable.
- `io_divisor` in DIVISOR_WIDTH: sets one oversample tick per (`io_divisor`+1) clocks.
- `io_parityEnable` in 1: when 1, the frame carries a parity bit after the data bits.
- `io_parityOdd` in 1: selects odd parity when 1, even parity when 0.
- `io_data` out 8: FIFO head byte.
- `io_valid` out 1: FIFO non-empty.
- `io_ready` in 1: consumer accepts the head byte.
- `io_parityError` out 1: one-clock pulse.
- `io_framingError` out 1: one-clock pulse.
- `io_overrun` out 1: one-clock pulse.
- `io_breakDetect` out 1: level.
- `io_busy` out 1: asserted whenever the FSM is not in IDLE.

## Operation

- Synchroniser: 2 flops, both reset to 1. The FSM uses only the synchronised value `rxs`.
- Tick generator: down-counter. It reloads `io_divisor` on reaching 0 and emits `tick`. It is forced to reload in IDLE, so phase aligns to the start edge. `io_divisor`=0 gives a tick every clock.
- Bit timing: a tick index 0..15 counts within each bit. Samples are taken at indices 7, 8 and 9; the bit value is the 2-of-3 majority, resolved at index 9. The bit ends at index 15.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge on `rxs` while `io_enable` is high moves to START with tick index 0.
  - START: a vote of 1 is a false start; return to IDLE with no flags. A vote of 0 proceeds to DATA at the end of the bit.
  - DATA: 8 bits are shifted in LSB-first. Go to PARITY if `io_parityEnable`, otherwise STOP.
  - PARITY: the vote is compared with the XOR of the data bits, inverted when `io_parityOdd`. The mismatch is latched.
  - STOP (acted on at the vote, not at bit end):
    - Vote 1: push the byte, pulse `io_parityError` if the mismatch is latched, and go to IDLE. A new start edge in the second half of the stop bit is therefore accepted.
    - Vote 0 with data non-zero: pulse `io_framingError`, discard the byte, go to IDLE.
    - Vote 0 with data 0x00: pulse `io_framingError`, set `io_breakDetect`, go to BREAK.
  - BREAK: wait for `rxs`=1, then clear `io_breakDetect` and go to IDLE. No start detection occurs in BREAK.
- Enable: `io_enable` low forces IDLE on the next clock. The frame in progress is abandoned with no flags, and FIFO contents are kept.
- FIFO: show-ahead, with `io_data` = head. A pop happens on `io_valid && io_ready`.
  - A push while full, with no simultaneous pop, drops the new byte and pulses `io_overrun`.
  - A simultaneous push and pop while full is accepted, with no overrun.
  - A pop while empty is ignored.
- Pointers are log2(FIFO_DEPTH)+1 bits, wrapping modulo 2·FIFO_DEPTH. Full means the MSBs differ and the lower bits are equal.
- Reset (asynchronous assert, mid-frame included): FSM to IDLE, FIFO empty. `io_valid`, `io_data`, all pulses, `io_breakDetect` and `io_busy` are all 0.

## Timing

- Synchroniser latency: 2 clocks from `io_rxd` to `rxs`.
- Bit period: 16·(`io_divisor`+1) clocks. The divisor is sampled continuously, so it must be changed only while `io_busy`=0.
- Push latency: `io_valid` rises, and `io_data` is updated when the FIFO was empty, on the clock after the stop-bit vote.
  - With `io_divisor`=0 and no parity, this is 2+16·9+10 = 156 clocks after the `io_rxd` falling edge, ±1.
- Error pulses are exactly 1 clock wide and coincide with the push cycle or discard cycle.
- Pop: the head advances on the clock after `io_valid && io_ready`. `io_valid` drops on the same edge when the last entry is popped.

## Test plan

- `io_divisor`=0, 8N1, send 0x55 then 0xA3 back-to-back with `io_ready`=1 → two `io_valid` beats with data 0x55 then 0xA3; the first beat appears at clock 156±1; no flags.
- Glitch: `io_rxd` low for 4 clocks at `io_divisor`=0 → no byte, no flags, and `io_busy` returns to 0 within 10 clocks.
- Framing error: send 0xA5 with stop bit 0, then a good 0x3C → one `io_framingError` pulse, 0xA5 not delivered, 0x3C delivered.
- Break and parity:
  - Hold `io_rxd` low for 20 bit times, then high → one `io_framingError` pulse; `io_breakDetect` high until 2 clocks after the line rises; no byte.
  - Odd parity, send 0x01 with parity bit 1 → 0x01 delivered with one `io_parityError` pulse.
- Overrun: `io_ready`=0, send 0x11..0x15 → one `io_overrun` at the 5th byte; draining yields 0x11, 0x12, 0x13, 0x14.
- Reset mid-frame: assert `resetn`=0 during DATA bit 3 → all outputs 0 immediately; after release, a fresh 0x7E is received correctly.
